// File: rtl/palette_expander.sv
// rtl/palette_expander.sv - double-buffered 16-entry palette expander, 8-bit index to 24-bit RGB
// Optional PALETTE_INTERP_EN: interpolate between adjacent entries (adds one pipeline stage).
module palette_expander #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sw_reset,
  input  logic [7:0]  vid_pData_i,
  input  logic        vid_pHSync_i,
  input  logic        vid_pVSync_i,
  input  logic        vid_pVDE_i,
  output logic [23:0] vid_pData_o,
  output logic        vid_pHSync_o,
  output logic        vid_pVSync_o,
  output logic        vid_pVDE_o,
  input  logic        palette_en,
  input  logic        pal_wr_en,
  input  logic [3:0]  pal_wr_addr,
  input  logic [23:0] pal_wr_data,
  input  logic        pal_commit,
  output logic        commit_pending
);

  logic [23:0] shadow_pal [16];
  logic [23:0] active_pal [16];

  logic [7:0]  y1;
  logic        hs1, vs1, vde1, pen1, vs_prev;
  logic        boundary, swap;
  logic [23:0] data_q;
  logic        hs_q, vs_q, vde_q;

  // Frame boundary is the inactive->active edge of the stage-1 vsync.
  assign boundary = (vs1 == VSYNC_ACTIVE_HIGH) && (vs_prev != VSYNC_ACTIVE_HIGH);
  assign swap     = boundary && (commit_pending || pal_commit) && !sw_reset;

  always_ff @(posedge clk) begin
    if (!resetn || sw_reset) commit_pending <= 1'b0;
    else if (boundary)       commit_pending <= 1'b0;
    else if (pal_commit)     commit_pending <= 1'b1;
  end

  // A coincident write lands in shadow only; the swap copies the pre-write contents.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) begin
        shadow_pal[i] <= {3{8'(i * 17)}};
        active_pal[i] <= {3{8'(i * 17)}};
      end
    end else begin
      if (swap) begin
        for (int i = 0; i < 16; i++) active_pal[i] <= shadow_pal[i];
      end
      if (pal_wr_en) shadow_pal[pal_wr_addr] <= pal_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || sw_reset) begin
      y1      <= 8'h00;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      vde1    <= 1'b0;
      pen1    <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      y1      <= vid_pData_i;
      hs1     <= vid_pHSync_i;
      vs1     <= vid_pVSync_i;
      vde1    <= vid_pVDE_i;
      pen1    <= palette_en;
      vs_prev <= vs1;
    end
  end

`ifdef PALETTE_INTERP_EN
  logic [23:0] p_lo, p_hi;
  logic [7:0]  y2;
  logic        hs2, vs2, vde2, pen2;
  logic [3:0]  idx_hi;

  assign idx_hi = (y1[7:4] == 4'hF) ? 4'hF : y1[7:4] + 4'd1;

  // Palette is read in stage 2 so a swap affects pixels that entered on or after it.
  always_ff @(posedge clk) begin
    if (!resetn || sw_reset) begin
      p_lo <= 24'h0;
      p_hi <= 24'h0;
      y2   <= 8'h00;
      hs2  <= 1'b0;
      vs2  <= 1'b0;
      vde2 <= 1'b0;
      pen2 <= 1'b0;
    end else begin
      p_lo <= active_pal[y1[7:4]];
      p_hi <= active_pal[idx_hi];
      y2   <= y1;
      hs2  <= hs1;
      vs2  <= vs1;
      vde2 <= vde1;
      pen2 <= pen1;
    end
  end

  function automatic logic [7:0] lerp(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] f);
    logic signed [9:0]  d;
    logic signed [13:0] p;
    logic signed [9:0]  s;
    logic signed [10:0] c;
    d = $signed({2'b00, b}) - $signed({2'b00, a});
    p = 14'(d) * 14'($signed({1'b0, f}));
    s = 10'(p >>> 4);
    c = $signed({3'b000, a}) + 11'(s);
    if (c < 0)        return 8'h00;
    else if (c > 255) return 8'hFF;
    else              return c[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || sw_reset) begin
      data_q <= 24'h0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      vde_q  <= 1'b0;
    end else begin
      if (!vde2)     data_q <= 24'h0;
      else if (pen2) data_q <= {lerp(p_lo[23:16], p_hi[23:16], y2[3:0]),
                                lerp(p_lo[15:8],  p_hi[15:8],  y2[3:0]),
                                lerp(p_lo[7:0],   p_hi[7:0],   y2[3:0])};
      else           data_q <= {3{y2}};
      hs_q  <= hs2;
      vs_q  <= vs2;
      vde_q <= vde2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!resetn || sw_reset) begin
      data_q <= 24'h0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      vde_q  <= 1'b0;
    end else begin
      if (!vde1)     data_q <= 24'h0;
      else if (pen1) data_q <= active_pal[y1[7:4]];
      else           data_q <= {3{y1}};
      hs_q  <= hs1;
      vs_q  <= vs1;
      vde_q <= vde1;
    end
  end
`endif

  assign vid_pData_o  = data_q;
  assign vid_pHSync_o = hs_q;
  assign vid_pVSync_o = vs_q;
  assign vid_pVDE_o   = vde_q;

endmodule

// File: tb/tb_palette_expander.sv
// tb/tb_palette_expander.sv - directed and random checks of palette_expander against a frame-level model
module tb_palette_expander;

`ifdef PALETTE_INTERP_EN
  localparam int LAT = 3;
  `define NEAR_CHK(t, g, e)
`else
  localparam int LAT = 2;
  `define NEAR_CHK(t, g, e) chk(t, g, e);
`endif
  localparam bit VSA = 1'b1;

  logic        clk, resetn, sw_reset;
  logic [7:0]  vid_pData_i;
  logic        vid_pHSync_i, vid_pVSync_i, vid_pVDE_i;
  logic [23:0] vid_pData_o;
  logic        vid_pHSync_o, vid_pVSync_o, vid_pVDE_o;
  logic        palette_en, pal_wr_en, pal_commit, commit_pending;
  logic [3:0]  pal_wr_addr;
  logic [23:0] pal_wr_data;

  palette_expander #(.VSYNC_ACTIVE_HIGH(VSA)) dut (
    .clk(clk), .resetn(resetn), .sw_reset(sw_reset),
    .vid_pData_i(vid_pData_i), .vid_pHSync_i(vid_pHSync_i),
    .vid_pVSync_i(vid_pVSync_i), .vid_pVDE_i(vid_pVDE_i),
    .vid_pData_o(vid_pData_o), .vid_pHSync_o(vid_pHSync_o),
    .vid_pVSync_o(vid_pVSync_o), .vid_pVDE_o(vid_pVDE_o),
    .palette_en(palette_en), .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .pal_commit(pal_commit), .commit_pending(commit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: two banks, a pending flag, the last two vsync inputs and expected outputs in flight.
  logic [23:0] m_shadow [16];
  logic [23:0] m_active [16];
  logic        m_pend, h1, h2, vs_r;
  logic [26:0] q [$];

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] expect_pix(input logic [7:0] y, input logic pen, input logic vde);
    int i;
`ifdef PALETTE_INTERP_EN
    int j, a, b, t, c;
    logic [23:0] r;
`endif
    if (!vde) return 24'h0;
    if (!pen) return {y, y, y};
    i = int'(y) / 16;
`ifdef PALETTE_INTERP_EN
    j = (i == 15) ? 15 : i + 1;
    r = 24'h0;
    for (int k = 0; k < 3; k++) begin
      a = int'((m_active[i] >> (8 * k)) & 24'hFF);
      b = int'((m_active[j] >> (8 * k)) & 24'hFF);
      t = (b - a) * (int'(y) % 16);
      c = a + ((t >= 0) ? t / 16 : -((15 - t) / 16));
      if (c < 0) c = 0;
      if (c > 255) c = 255;
      r = r | (24'(c) << (8 * k));
    end
    return r;
`else
    return m_active[i];
`endif
  endfunction

  task automatic cyc(input logic [7:0] y, input logic hs, input logic vs, input logic vde,
                     input logic pen, input logic we, input logic [3:0] wa,
                     input logic [23:0] wd, input logic cm, input logic sw);
    logic        bnd;
    logic [26:0] e, exp_v;
    vid_pData_i = y; vid_pHSync_i = hs; vid_pVSync_i = vs; vid_pVDE_i = vde;
    palette_en = pen; pal_wr_en = we; pal_wr_addr = wa; pal_wr_data = wd;
    pal_commit = cm; sw_reset = sw;
    bnd = (h1 == VSA) && (h2 != VSA);
    if (sw) m_pend = 1'b0;
    else begin
      if (bnd && (m_pend || cm)) m_active = m_shadow;
      m_pend = bnd ? 1'b0 : (m_pend || cm);
    end
    e = {hs, vs, vde, expect_pix(y, pen, vde)};
    if (sw) begin
      q.delete();
      repeat (LAT - 1) q.push_back(27'h0);
      exp_v = 27'h0;
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      if (we) m_shadow[wa] = wd;
      q.push_back(e);
      exp_v = q.pop_front();
      h2 = h1;
      h1 = vs;
    end
    @(posedge clk);
    #1;
    chk("data", vid_pData_o, exp_v[23:0]);
    chk("vde", 24'(vid_pVDE_o), 24'(exp_v[24]));
    chk("vsync", 24'(vid_pVSync_o), 24'(exp_v[25]));
    chk("hsync", 24'(vid_pHSync_o), 24'(exp_v[26]));
    chk("pending", 24'(commit_pending), 24'(m_pend));
  endtask

  task automatic pix(input logic [7:0] y, input logic pen, input logic vde, input logic vs);
    cyc(y, 1'b0, vs, vde, pen, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic flush(input logic vs);
    repeat (LAT - 1) pix(8'h00, 1'b0, 1'b0, vs);
  endtask

  initial begin
    resetn = 1'b0; sw_reset = 1'b0;
    vid_pData_i = 8'h00; vid_pHSync_i = 1'b1; vid_pVSync_i = 1'b1; vid_pVDE_i = 1'b1;
    palette_en = 1'b1; pal_commit = 1'b1; pal_wr_en = 1'b1;
    pal_wr_addr = 4'h5; pal_wr_data = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", vid_pData_o, 24'h0);
    chk("rst_vde", 24'(vid_pVDE_o), 24'h0);
    chk("rst_syncs", 24'({vid_pHSync_o, vid_pVSync_o}), 24'h0);
    chk("rst_pending", 24'(commit_pending), 24'h0);
    for (int i = 0; i < 16; i++) m_shadow[i] = {3{8'(i * 17)}};
    m_active = m_shadow;
    m_pend = 1'b0; h1 = 1'b0; h2 = 1'b0; vs_r = 1'b0;
    repeat (LAT - 1) q.push_back(27'h0);
    resetn = 1'b1;

    // Ramp entry 5 after reset
    pix(8'h5A, 1'b1, 1'b1, 1'b0);
    flush(1'b0);
    `NEAR_CHK("req032", vid_pData_o, 24'h555555)

    // Shadow write without commit never reaches video
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 24'hFF0000, 1'b0, 1'b0);
    repeat (3) pix(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) pix(8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h30, 1'b1, 1'b1, 1'b0);
    flush(1'b0);
    chk("req033", vid_pData_o, 24'h333333);

    // Mid-frame commit (repeated), swap at the vsync boundary
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1, 1'b0);
    chk("req034_set", 24'(commit_pending), 24'h1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1, 1'b0);
    pix(8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h3F, 1'b1, 1'b1, 1'b1);
    chk("req034_hold", 24'(commit_pending), 24'h1);
    pix(8'h3F, 1'b1, 1'b1, 1'b1);
    chk("req034_clr", 24'(commit_pending), 24'h0);
    `NEAR_CHK("req034_old", vid_pData_o, 24'h333333)
    flush(1'b1);
    `NEAR_CHK("req034_new", vid_pData_o, 24'hFF0000)

    // Commit and write in the boundary cycle itself
    repeat (3) pix(8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h30, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 24'h00FF00, 1'b1, 1'b0);
    chk("req035_pend", 24'(commit_pending), 24'h0);
    flush(1'b1);
    chk("req035_active", vid_pData_o, 24'hFF0000);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1, 1'b0);
    repeat (2) pix(8'h00, 1'b0, 1'b0, 1'b0);
    pix(8'h00, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 1'b1, 1'b1, 1'b1);
    flush(1'b1);
    chk("req035_shadow", vid_pData_o, 24'h00FF00);

    // Grey bypass and blanking
    pix(8'hC8, 1'b0, 1'b1, 1'b0);
    flush(1'b0);
    chk("req036_grey", vid_pData_o, 24'hC8C8C8);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    flush(1'b0);
    chk("req036_blank", vid_pData_o, 24'h000000);
    chk("req036_hs", 24'(vid_pHSync_o), 24'h1);
    vs_r = 1'b0;

`ifdef PALETTE_INTERP_EN
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 24'h000000, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 24'h101010, 1'b1, 1'b0);
    pix(8'h00, 1'b0, 1'b0, 1'b1);
    pix(8'h08, 1'b1, 1'b1, 1'b1);
    flush(1'b1);
    chk("req037", vid_pData_o, 24'h080808);
    vs_r = 1'b1;
`endif

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) vs_r = ~vs_r;
      cyc(8'($urandom), 1'($urandom), vs_r, $urandom_range(3) != 0, $urandom_range(3) != 0,
          $urandom_range(3) == 0, 4'($urandom), 24'($urandom), $urandom_range(23) == 0, 1'b0);
    end

    // Soft clear keeps both palettes
    cyc(8'h00, 1'b0, vs_r, 1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 1'b1, 1'b0);
    cyc(8'h77, 1'b1, vs_r, 1'b1, 1'b1, 1'b0, 4'h0, 24'h0, 1'b1, 1'b1);
    chk("swrst_pending", 24'(commit_pending), 24'h0);
    for (int n = 0; n < 20; n++) pix(8'($urandom), 1'b1, 1'b1, vs_r);
    flush(vs_r);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
